// File: rtl/shift_unit.sv
// shift_unit: two-stage valid/ready barrel shifter.
// Stage 1 captures the decoded request and stage 2 captures the result and
// flags. The shift itself is evaluated combinationally between the stages.
// Supported operations are LSL, LSR, ASR, ROR and RRX, each with a carry-out.
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_illegal,
  output logic             err_sticky
);

  // WIDTH is a power of two, so the rotate amount is the low bits of in_amt.
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    K_LSL = 3'd0,
    K_LSR = 3'd1,
    K_ASR = 3'd2,
    K_ROR = 3'd3,
    K_RRX = 3'd4,
    K_ILL = 3'd5
  } kind_e;

  // Stage 1 registers: the decoded request.
  logic             s1_valid_q, s1_valid_d;
  kind_e            s1_kind_q,  s1_kind_d;
  logic             s1_zero_q,  s1_zero_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [AMT_W-1:0] s1_amt_q,   s1_amt_d;
  logic             s1_cin_q,   s1_cin_d;

  // Stage 2 registers: the result and its flags.
  logic             s2_valid_q,   s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,    s2_data_d;
  logic             s2_cout_q,    s2_cout_d;
  logic             s2_illegal_q, s2_illegal_d;

  logic             err_q, err_d;

  // Handshake and control.
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  kind_e            in_kind;

  // Intermediate shift results.
  logic [WIDTH:0]          lsl_ext;
  logic [WIDTH:0]          lsr_ext;
  logic signed [WIDTH:0]   asr_ext;
  logic [2*WIDTH-1:0]      ror_ext;
  logic [SW-1:0]           rot_amt;
  logic [WIDTH-1:0]        res_data;
  logic                    res_cout;
  logic                    res_illegal;

  // Pipeline advance conditions. in_ready is held low during reset so that
  // nothing is accepted while the pipeline is being cleared.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = !rst && s1_adv;
    accept   = in_valid && in_ready;
  end

  // Map the raw opcode onto an operation kind; 101..111 fold into K_ILL.
  always_comb begin
    in_kind = K_ILL;
    case (in_op)
      3'b000:  in_kind = K_LSL;
      3'b001:  in_kind = K_LSR;
      3'b010:  in_kind = K_ASR;
      3'b011:  in_kind = K_ROR;
      3'b100:  in_kind = K_RRX;
      default: in_kind = K_ILL;
    endcase
  end

  // Stage 1 next state: load on acceptance, empty when advancing without input.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_kind_d  = s1_kind_q;
    s1_zero_d  = s1_zero_q;
    s1_data_d  = s1_data_q;
    s1_amt_d   = s1_amt_q;
    s1_cin_d   = s1_cin_q;
    if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_kind_d = in_kind;
      s1_zero_d = (in_amt == '0);
      s1_data_d = in_data;
      s1_amt_d  = in_amt;
      s1_cin_d  = in_cin;
    end
  end

  // Shift datapath. The operand is widened by one bit so the bit shifted out
  // last lands in the extra position; this covers amounts 1..WIDTH and also
  // makes larger amounts yield zero (or sign fill) with the correct carry.
  always_comb begin
    lsl_ext = {1'b0, s1_data_q} << s1_amt_q;
    lsr_ext = {s1_data_q, 1'b0} >> s1_amt_q;
    asr_ext = $signed({s1_data_q, 1'b0}) >>> s1_amt_q;
    rot_amt = s1_amt_q[SW-1:0];
    ror_ext = {s1_data_q, s1_data_q} >> rot_amt;
  end

  // Select the result for the decoded operation. A zero amount leaves the
  // operand and the incoming carry unchanged for all amount-based shifts.
  always_comb begin
    res_data    = s1_data_q;
    res_cout    = s1_cin_q;
    res_illegal = 1'b0;
    case (s1_kind_q)
      K_LSL: begin
        if (!s1_zero_q) begin
          res_data = lsl_ext[WIDTH-1:0];
          res_cout = lsl_ext[WIDTH];
        end
      end
      K_LSR: begin
        if (!s1_zero_q) begin
          res_data = lsr_ext[WIDTH:1];
          res_cout = lsr_ext[0];
        end
      end
      K_ASR: begin
        if (!s1_zero_q) begin
          res_data = asr_ext[WIDTH:1];
          res_cout = asr_ext[0];
        end
      end
      K_ROR: begin
        // A multiple of WIDTH rotates back to the operand; the carry is
        // still the top result bit, which equals in[WIDTH-1] in that case.
        if (!s1_zero_q) begin
          res_data = ror_ext[WIDTH-1:0];
          res_cout = ror_ext[WIDTH-1];
        end
      end
      K_RRX: begin
        res_data = {s1_cin_q, s1_data_q[WIDTH-1:1]};
        res_cout = s1_data_q[0];
      end
      default: begin
        res_illegal = 1'b1;
      end
    endcase
  end

  // Stage 2 next state: results only change when the stage advances, which
  // keeps the outputs stable while the consumer is stalling.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_cout_d    = s2_cout_q;
    s2_illegal_d = s2_illegal_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d    = res_data;
        s2_cout_d    = res_cout;
        s2_illegal_d = res_illegal;
      end
    end
  end

  // Sticky error flag: set as soon as an illegal request is accepted.
  always_comb begin
    err_d = err_q || (accept && (in_kind == K_ILL));
  end

  // State registers with synchronous reset; reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_kind_q    <= K_LSL;
      s1_zero_q    <= 1'b0;
      s1_data_q    <= '0;
      s1_amt_q     <= '0;
      s1_cin_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_cout_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_kind_q    <= s1_kind_d;
      s1_zero_q    <= s1_zero_d;
      s1_data_q    <= s1_data_d;
      s1_amt_q     <= s1_amt_d;
      s1_cin_q     <= s1_cin_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_cout_q    <= s2_cout_d;
      s2_illegal_q <= s2_illegal_d;
      err_q        <= err_d;
    end
  end

  // Output drive straight from the stage 2 registers.
  always_comb begin
    out_valid   = s2_valid_q;
    out_data    = s2_data_q;
    out_cout    = s2_cout_q;
    out_illegal = s2_illegal_q;
    err_sticky  = err_q;
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=32, AMT_W=8).
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_amt;
  logic [2:0]  in_op;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_cout;
  logic        out_illegal;
  logic        err_sticky;

  int total = 0;
  int bad   = 0;

  // Back-to-back burst: LSL 1<<1, LSR 0x10>>4, ROR 1 by 1, RRX 2 cin0.
  logic [2:0]  b_op [4] = '{3'b000, 3'b001, 3'b011, 3'b100};
  logic [31:0] b_in [4] = '{32'h1, 32'h10, 32'h1, 32'h2};
  logic [7:0]  b_amt[4] = '{8'd1, 8'd4, 8'd1, 8'd0};
  logic [31:0] b_exp[4] = '{32'h2, 32'h1, 32'h8000_0000, 32'h1};
  logic        b_c  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  shift_unit #(.WIDTH(32), .AMT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .in_cin     (in_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cout   (out_cout),
    .out_illegal(out_illegal),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request with out_ready high; result checked two cycles after accept.
  task automatic run1(input string tag, input logic [2:0] op, input logic [31:0] d,
                      input logic [7:0] amt, input logic cin,
                      input logic [31:0] ed, input logic ec, input logic eill);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_amt    = amt;
    in_cin    = cin;
    #1 chk({tag, "_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_cout"}, out_cout, ec);
    chk({tag, "_illegal"}, out_illegal, eill);
    $display("txn %s op=%b in=%h amt=%0d cin=%b -> data=%h cout=%b ill=%b",
             tag, op, d, amt, cin, out_data, out_cout, out_illegal);
  endtask

  initial begin
    int sent;
    int rcv;
    int stale;
    logic held;
    logic [31:0] hd;
    logic hc;
    logic saw_low;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amt = '0; in_op = '0; in_cin = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_err", err_sticky, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 1);

    // Directed single operations.
    run1("ror1",      3'b011, 32'h8000_0001, 8'd1,   1'b0, 32'hC000_0000, 1'b1, 1'b0);
    run1("lsl32",     3'b000, 32'h0000_0001, 8'd32,  1'b0, 32'h0,         1'b1, 1'b0);
    run1("lsl33",     3'b000, 32'h0000_0001, 8'd33,  1'b1, 32'h0,         1'b0, 1'b0);
    run1("asr200",    3'b010, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run1("rrx",       3'b100, 32'h0000_0003, 8'd77,  1'b1, 32'h8000_0001, 1'b1, 1'b0);
    run1("lsl4",      3'b000, 32'h1234_5678, 8'd4,   1'b0, 32'h2345_6780, 1'b1, 1'b0);
    run1("lsr4",      3'b001, 32'h1234_5678, 8'd4,   1'b0, 32'h0123_4567, 1'b1, 1'b0);
    run1("lsl0",      3'b000, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1'b0);
    run1("lsr32",     3'b001, 32'h8000_0000, 8'd32,  1'b0, 32'h0,         1'b1, 1'b0);
    run1("asr31",     3'b010, 32'h4000_0000, 8'd31,  1'b0, 32'h0,         1'b1, 1'b0);
    run1("ror32",     3'b011, 32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 1'b0);
    run1("ror36",     3'b011, 32'h0000_000F, 8'd36,  1'b0, 32'hF000_0000, 1'b1, 1'b0);
    chk("err_clear_legal", err_sticky, 0);

    // Illegal operation and sticky error.
    run1("illegal",   3'b110, 32'hDEAD_BEEF, 8'd5,   1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("err_set", err_sticky, 1);
    run1("after_ill", 3'b001, 32'h0000_00F0, 8'd4,   1'b0, 32'h0000_000F, 1'b0, 1'b0);
    chk("err_hold", err_sticky, 1);

    // Burst of 4 with out_ready low for 3 cycles after the first accept.
    sent = 0; rcv = 0; held = 1'b0; hd = '0; hc = 1'b0; saw_low = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 1 && c <= 3);
      if (sent < 4) begin
        in_valid = 1'b1;
        in_op    = b_op[sent];
        in_data  = b_in[sent];
        in_amt   = b_amt[sent];
        in_cin   = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        chk("stall_hold_data", out_data, hd);
        chk("stall_hold_cout", out_cout, hc);
      end
      held = out_valid && !out_ready;
      hd   = out_data;
      hc   = out_cout;
      if (in_valid && !in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        if (rcv < 4) begin
          chk($sformatf("burst%0d_data", rcv), out_data, b_exp[rcv]);
          chk($sformatf("burst%0d_cout", rcv), out_cout, b_c[rcv]);
          $display("txn burst%0d data=%h cout=%b", rcv, out_data, out_cout);
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("burst_ready_fell", saw_low, 1);
    chk("burst_sent", sent, 4);
    chk("burst_received", rcv, 4);

    // Reset with both stages full: nothing survives.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b000; in_data = 32'h5; in_amt = 8'd1;
    @(negedge clk);
    in_data = 32'h6;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("full_out_valid", out_valid, 1);
    rst = 1'b1;
    #1 chk("rst_hi_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_err", err_sticky, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("flush_rel_ready", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (out_valid) stale++;
    end
    chk("flush_no_stale", stale, 0);
    $display("txn reset_flush stale=%0d", stale);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
